// File: rtl/idu_pipe.sv
// idu_pipe: registered RV32I/RV64I instruction-decode stage with valid/ready
// flow control, flush and a count of bundles handed downstream.
// Optional M-extension decode is enabled by defining IDU_PIPE_RVM_EN; without
// it every funct7=0000001 R/RW encoding decodes as illegal.
module idu_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic              rs1_en,
  output logic              rs2_en,
  output logic              wr_reg_en,
  output logic [XLEN-1:0]   imm,
  output logic [24:0]       alu_ctrl,
  output logic              alu_w_op,
  output logic [3:0]        pc_src,
  output logic              rd_mem_en,
  output logic              wr_mem_en,
  output logic [3:0]        mem_len,
  output logic              mem_unsigned,
  output logic              mem2reg_en,
  output logic              ebreak,
  output logic              illegal,
  output logic [CNT_W-1:0]  dec_cnt
);

  localparam logic IS64 = (XLEN == 64);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  // Immediates are built at 64 bits and truncated, so XLEN=32 needs no
  // zero-width replications.
  logic [63:0] imm_i64, imm_s64, imm_b64, imm_u64, imm_j64, sh6_64, sh5_64;
  assign imm_i64 = {{52{in_instr[31]}}, in_instr[31:20]};
  assign imm_s64 = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b64 = {{52{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u64 = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
  assign imm_j64 = {{44{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign sh6_64  = {58'b0, in_instr[25:20]};
  assign sh5_64  = {59'b0, in_instr[24:20]};

  logic            d_rs1_en, d_rs2_en, d_wr, d_w, d_rdm, d_wrm, d_uns, d_m2r, d_ebreak, d_ill;
  logic [XLEN-1:0] d_imm;
  logic [24:0]     d_alu;
  logic [3:0]      d_pc_src, d_len;

  // Combinational decode of the incoming instruction into a control bundle.
  always_comb begin
    d_rs1_en = 1'b0; d_rs2_en = 1'b0; d_wr = 1'b0; d_w = 1'b0;
    d_rdm = 1'b0; d_wrm = 1'b0; d_uns = 1'b0; d_m2r = 1'b0;
    d_ebreak = 1'b0; d_ill = 1'b0;
    d_imm = '0; d_alu = '0; d_pc_src = '0; d_len = '0;
    // Every known opcode ends in 2'b11, so a compressed/bad low pair lands
    // in the default arm below.
    case (opc)
      OP_LUI: begin
        d_alu[10] = 1'b1; d_imm = imm_u64[XLEN-1:0]; d_wr = 1'b1;
      end
      OP_AUIPC: begin
        d_alu[0] = 1'b1; d_pc_src[3] = 1'b1; d_imm = imm_u64[XLEN-1:0]; d_wr = 1'b1;
      end
      OP_JAL: begin
        d_alu[0] = 1'b1; d_pc_src[1] = 1'b1; d_imm = imm_j64[XLEN-1:0]; d_wr = 1'b1;
      end
      OP_JALR: begin
        d_alu[0] = 1'b1; d_pc_src[2] = 1'b1; d_imm = imm_i64[XLEN-1:0];
        d_rs1_en = 1'b1; d_wr = 1'b1;
        if (f3 != 3'b000) d_ill = 1'b1;
      end
      OP_BRANCH: begin
        d_pc_src[0] = 1'b1; d_rs1_en = 1'b1; d_rs2_en = 1'b1;
        d_imm = imm_b64[XLEN-1:0];
        case (f3)
          3'b000: d_alu[11] = 1'b1;
          3'b001: d_alu[12] = 1'b1;
          3'b100: d_alu[13] = 1'b1;
          3'b101: d_alu[14] = 1'b1;
          3'b110: d_alu[15] = 1'b1;
          3'b111: d_alu[16] = 1'b1;
          default: d_ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        d_alu[0] = 1'b1; d_rs1_en = 1'b1; d_imm = imm_i64[XLEN-1:0];
        d_rdm = 1'b1; d_m2r = 1'b1; d_wr = 1'b1;
        case (f3)
          3'b000: d_len = 4'd1;
          3'b001: d_len = 4'd2;
          3'b010: d_len = 4'd4;
          3'b011: begin d_len = 4'd8; d_ill = !IS64; end
          3'b100: begin d_len = 4'd1; d_uns = 1'b1; end
          3'b101: begin d_len = 4'd2; d_uns = 1'b1; end
          3'b110: begin d_len = 4'd4; d_uns = 1'b1; d_ill = !IS64; end
          default: d_ill = 1'b1;
        endcase
      end
      OP_STORE: begin
        d_alu[0] = 1'b1; d_rs1_en = 1'b1; d_rs2_en = 1'b1;
        d_imm = imm_s64[XLEN-1:0]; d_wrm = 1'b1;
        case (f3)
          3'b000: d_len = 4'd1;
          3'b001: d_len = 4'd2;
          3'b010: d_len = 4'd4;
          3'b011: begin d_len = 4'd8; d_ill = !IS64; end
          default: d_ill = 1'b1;
        endcase
      end
      OP_IMM: begin
        d_rs1_en = 1'b1; d_wr = 1'b1; d_imm = imm_i64[XLEN-1:0];
        case (f3)
          3'b000: d_alu[0] = 1'b1;
          3'b010: d_alu[2] = 1'b1;
          3'b011: d_alu[3] = 1'b1;
          3'b100: d_alu[5] = 1'b1;
          3'b110: d_alu[6] = 1'b1;
          3'b111: d_alu[4] = 1'b1;
          3'b001: begin
            d_alu[7] = 1'b1;
            d_imm = IS64 ? sh6_64[XLEN-1:0] : sh5_64[XLEN-1:0];
            if (in_instr[31:26] != 6'b0 || (!IS64 && in_instr[25])) d_ill = 1'b1;
          end
          default: begin  // 3'b101: srli/srai, instr[30] selects arithmetic
            if (in_instr[30]) d_alu[9] = 1'b1;
            else              d_alu[8] = 1'b1;
            d_imm = IS64 ? sh6_64[XLEN-1:0] : sh5_64[XLEN-1:0];
            if ({in_instr[31], in_instr[29:26]} != 5'b0 || (!IS64 && in_instr[25])) d_ill = 1'b1;
          end
        endcase
      end
      OP_IMM32: begin
        d_rs1_en = 1'b1; d_wr = 1'b1; d_w = 1'b1;
        if (!IS64) d_ill = 1'b1;
        case (f3)
          3'b000: begin d_alu[0] = 1'b1; d_imm = imm_i64[XLEN-1:0]; end
          3'b001: begin
            d_alu[7] = 1'b1; d_imm = sh5_64[XLEN-1:0];
            if (f7 != 7'b0) d_ill = 1'b1;
          end
          3'b101: begin
            if (in_instr[30]) d_alu[9] = 1'b1;
            else              d_alu[8] = 1'b1;
            d_imm = sh5_64[XLEN-1:0];
            if ({in_instr[31], in_instr[29:25]} != 6'b0) d_ill = 1'b1;
          end
          default: d_ill = 1'b1;
        endcase
      end
      OP_OP: begin
        d_rs1_en = 1'b1; d_rs2_en = 1'b1; d_wr = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000: d_alu[0] = 1'b1;
              3'b001: d_alu[7] = 1'b1;
              3'b010: d_alu[2] = 1'b1;
              3'b011: d_alu[3] = 1'b1;
              3'b100: d_alu[5] = 1'b1;
              3'b101: d_alu[8] = 1'b1;
              3'b110: d_alu[6] = 1'b1;
              default: d_alu[4] = 1'b1;
            endcase
          end
          7'b0100000: begin
            case (f3)
              3'b000: d_alu[1] = 1'b1;
              3'b101: d_alu[9] = 1'b1;
              default: d_ill = 1'b1;
            endcase
          end
          7'b0000001: begin
`ifdef IDU_PIPE_RVM_EN
            d_alu[5'd17 + {2'b00, f3}] = 1'b1;
`else
            d_ill = 1'b1;
`endif
          end
          default: d_ill = 1'b1;
        endcase
      end
      OP_OP32: begin
        d_rs1_en = 1'b1; d_rs2_en = 1'b1; d_wr = 1'b1; d_w = 1'b1;
        if (!IS64) d_ill = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000: d_alu[0] = 1'b1;
              3'b001: d_alu[7] = 1'b1;
              3'b101: d_alu[8] = 1'b1;
              default: d_ill = 1'b1;
            endcase
          end
          7'b0100000: begin
            case (f3)
              3'b000: d_alu[1] = 1'b1;
              3'b101: d_alu[9] = 1'b1;
              default: d_ill = 1'b1;
            endcase
          end
          7'b0000001: begin
`ifdef IDU_PIPE_RVM_EN
            case (f3)
              3'b000: d_alu[17] = 1'b1;
              3'b100: d_alu[21] = 1'b1;
              3'b101: d_alu[22] = 1'b1;
              3'b110: d_alu[23] = 1'b1;
              3'b111: d_alu[24] = 1'b1;
              default: d_ill = 1'b1;
            endcase
`else
            d_ill = 1'b1;
`endif
          end
          default: d_ill = 1'b1;
        endcase
      end
      OP_SYSTEM: begin
        if (in_instr == 32'h00100073) d_ebreak = 1'b1;
        else                          d_ill = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    // An illegal encoding must not trigger any side effect downstream.
    if (d_ill) begin
      d_rs1_en = 1'b0; d_rs2_en = 1'b0; d_wr = 1'b0; d_w = 1'b0;
      d_rdm = 1'b0; d_wrm = 1'b0; d_uns = 1'b0; d_m2r = 1'b0;
      d_alu = '0; d_pc_src = '0; d_len = '0;
    end
  end

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load;

  assign in_ready = ~valid_q | out_ready;
  assign load     = in_valid & in_ready & ~flush;

  // Next-state for the valid flag and the downstream-accept counter.
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (flush)          valid_d = 1'b0;
    else if (load)      valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
    if (valid_q & out_ready & ~flush) cnt_d = cnt_q + CNT_W'(1);
  end

  logic [XLEN-1:0] pc_q, imm_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic            rs1_en_q, rs2_en_q, wr_q, w_q, rdm_q, wrm_q, uns_q, m2r_q, ebreak_q, ill_q;
  logic [24:0]     alu_q;
  logic [3:0]      pc_src_q, len_q;

  // Output pipeline register: loads a fresh bundle, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0; cnt_q <= '0; pc_q <= '0; imm_q <= '0;
      rs1_q <= '0; rs2_q <= '0; rd_q <= '0;
      rs1_en_q <= 1'b0; rs2_en_q <= 1'b0; wr_q <= 1'b0; w_q <= 1'b0;
      rdm_q <= 1'b0; wrm_q <= 1'b0; uns_q <= 1'b0; m2r_q <= 1'b0;
      ebreak_q <= 1'b0; ill_q <= 1'b0; alu_q <= '0; pc_src_q <= '0; len_q <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (load) begin
        pc_q <= in_pc; imm_q <= d_imm;
        rs1_q <= in_instr[19:15]; rs2_q <= in_instr[24:20]; rd_q <= in_instr[11:7];
        rs1_en_q <= d_rs1_en; rs2_en_q <= d_rs2_en;
        wr_q <= d_wr & ~d_ebreak; w_q <= d_w;
        rdm_q <= d_rdm; wrm_q <= d_wrm; uns_q <= d_uns; m2r_q <= d_m2r;
        ebreak_q <= d_ebreak; ill_q <= d_ill; alu_q <= d_alu;
        pc_src_q <= d_pc_src; len_q <= d_len;
      end
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign rs1          = rs1_q;
  assign rs2          = rs2_q;
  assign rd           = rd_q;
  assign rs1_en       = rs1_en_q;
  assign rs2_en       = rs2_en_q;
  assign wr_reg_en    = wr_q;
  assign imm          = imm_q;
  assign alu_ctrl     = alu_q;
  assign alu_w_op     = w_q;
  assign pc_src       = pc_src_q;
  assign rd_mem_en    = rdm_q;
  assign wr_mem_en    = wrm_q;
  assign mem_len      = len_q;
  assign mem_unsigned = uns_q;
  assign mem2reg_en   = m2r_q;
  assign ebreak       = ebreak_q;
  assign illegal      = ill_q;
  assign dec_cnt      = cnt_q;

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: an XLEN=64 instance checked through a scoreboard and an
// XLEN=32 instance (3-bit counter, so it wraps) checked inline.
module tb_idu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        in_ready, out_valid, rs1_en, rs2_en, wr_reg_en, alu_w_op;
  logic        rd_mem_en, wr_mem_en, mem_unsigned, mem2reg_en, ebreak, illegal;
  logic [63:0] out_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [24:0] alu_ctrl;
  logic [3:0]  pc_src, mem_len;
  logic [31:0] dec_cnt;

  logic        in_ready_32, out_valid_32, rs1_en_32, rs2_en_32, wr_reg_en_32, alu_w_op_32;
  logic        rd_mem_en_32, wr_mem_en_32, mem_unsigned_32, mem2reg_en_32, ebreak_32, illegal_32;
  logic [31:0] out_pc_32, imm_32;
  logic [4:0]  rs1_32, rs2_32, rd_32;
  logic [24:0] alu_ctrl_32;
  logic [3:0]  pc_src_32, mem_len_32;
  logic [2:0]  dec_cnt_32;

  idu_pipe #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rs1_en(rs1_en), .rs2_en(rs2_en),
    .wr_reg_en(wr_reg_en), .imm(imm), .alu_ctrl(alu_ctrl), .alu_w_op(alu_w_op),
    .pc_src(pc_src), .rd_mem_en(rd_mem_en), .wr_mem_en(wr_mem_en),
    .mem_len(mem_len), .mem_unsigned(mem_unsigned), .mem2reg_en(mem2reg_en),
    .ebreak(ebreak), .illegal(illegal), .dec_cnt(dec_cnt)
  );

  idu_pipe #(.XLEN(32), .CNT_W(3)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
    .out_valid(out_valid_32), .out_ready(out_ready), .out_pc(out_pc_32),
    .rs1(rs1_32), .rs2(rs2_32), .rd(rd_32), .rs1_en(rs1_en_32), .rs2_en(rs2_en_32),
    .wr_reg_en(wr_reg_en_32), .imm(imm_32), .alu_ctrl(alu_ctrl_32), .alu_w_op(alu_w_op_32),
    .pc_src(pc_src_32), .rd_mem_en(rd_mem_en_32), .wr_mem_en(wr_mem_en_32),
    .mem_len(mem_len_32), .mem_unsigned(mem_unsigned_32), .mem2reg_en(mem2reg_en_32),
    .ebreak(ebreak_32), .illegal(illegal_32), .dec_cnt(dec_cnt_32)
  );

  typedef struct {
    logic [63:0] pc;
    logic [24:0] alu;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        wr, ill, rdm, w, ebk;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;
  int   seq    = 0;

  logic [31:0] t_instr [12];
  logic [24:0] t_alu   [12];
  logic [63:0] t_imm   [12];
  logic [4:0]  t_rd    [12];
  logic        t_wr [12], t_ill [12], t_rdm [12], t_w [12], t_ebk [12];

  task automatic set_entry(input int k, input logic [31:0] ins, input logic [24:0] alu,
                           input logic [63:0] im, input logic [4:0] r, input logic wr,
                           input logic ill, input logic rdm, input logic w, input logic ebk);
    t_instr[k] = ins; t_alu[k] = alu; t_imm[k] = im; t_rd[k] = r;
    t_wr[k] = wr; t_ill[k] = ill; t_rdm[k] = rdm; t_w[k] = w; t_ebk[k] = ebk;
  endtask

  task automatic init_table;
    set_entry(0,  32'hfff00093, 25'h1,     64'hffffffffffffffff, 5'd1,  1, 0, 0, 0, 0); // addi x1,x0,-1
    set_entry(1,  32'h42115113, 25'h200,   64'd33,               5'd2,  1, 0, 0, 0, 0); // srai x2,x2,33
    set_entry(2,  32'h0000b183, 25'h1,     64'd0,                5'd3,  1, 0, 1, 0, 0); // ld x3,0(x1)
`ifdef IDU_PIPE_RVM_EN
    set_entry(3,  32'h022081b3, 25'h20000, 64'd0,                5'd3,  1, 0, 0, 0, 0); // mul
`else
    set_entry(3,  32'h022081b3, 25'h0,     64'd0,                5'd3,  0, 1, 0, 0, 0); // mul (no M)
`endif
    set_entry(4,  32'h00208463, 25'h800,   64'd8,                5'd8,  0, 0, 0, 0, 0); // beq +8
    set_entry(5,  32'h800002b7, 25'h400,   64'hffffffff80000000, 5'd5,  1, 0, 0, 0, 0); // lui
    set_entry(6,  32'h0020833b, 25'h1,     64'd0,                5'd6,  1, 0, 0, 1, 0); // addw
    set_entry(7,  32'h0000000f, 25'h0,     64'd0,                5'd0,  0, 1, 0, 0, 0); // fence: unknown
    set_entry(8,  32'h402093b3, 25'h0,     64'd0,                5'd7,  0, 1, 0, 0, 0); // f7=0100000 on sll
    set_entry(9,  32'h00100073, 25'h0,     64'd0,                5'd0,  0, 0, 0, 0, 1); // ebreak
    set_entry(10, 32'h0020b823, 25'h1,     64'd16,               5'd16, 0, 0, 0, 0, 0); // sd x2,16(x1)
    set_entry(11, 32'h010000ef, 25'h1,     64'd16,               5'd1,  1, 0, 0, 0, 0); // jal x1,+16
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k);
    in_instr    = t_instr[k];
    in_pc       = 64'h8000_0000_0000_1000 + 64'(seq) * 64'd4;
    seq++;
    cur_exp.pc  = in_pc;   cur_exp.alu = t_alu[k]; cur_exp.imm = t_imm[k];
    cur_exp.rd  = t_rd[k]; cur_exp.wr  = t_wr[k];  cur_exp.ill = t_ill[k];
    cur_exp.rdm = t_rdm[k]; cur_exp.w  = t_w[k];   cur_exp.ebk = t_ebk[k];
    in_valid    = 1'b1;
  endtask

  // Scoreboard: pop on downstream handshake, push on accepted input.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && flush) begin
        if (sb.size() > 0) e = sb.pop_front();
      end else if (out_valid && out_ready) begin
        n_acc++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: bundle pc=%h with nothing expected", out_pc);
        end else begin
          e = sb.pop_front();
          if (out_pc !== e.pc || alu_ctrl !== e.alu || imm !== e.imm) begin
            errors++;
            $display("FAIL sb_data: pc=%h exp %h alu=%h exp %h imm=%h exp %h",
                     out_pc, e.pc, alu_ctrl, e.alu, imm, e.imm);
          end
          checks++;
          if ({rd, wr_reg_en, illegal, rd_mem_en, alu_w_op, ebreak} !==
              {e.rd, e.wr, e.ill, e.rdm, e.w, e.ebk}) begin
            errors++;
            $display("FAIL sb_ctrl pc=%h: rd/wr/ill/rdm/w/ebk=%0d/%b/%b/%b/%b/%b exp %0d/%b/%b/%b/%b/%b",
                     out_pc, rd, wr_reg_en, illegal, rd_mem_en, alu_w_op, ebreak,
                     e.rd, e.wr, e.ill, e.rdm, e.w, e.ebk);
          end
        end
      end
      if (in_valid && in_ready && !flush) sb.push_back(cur_exp);
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) tick;
    checks++;
    if (out_valid !== 1'b0 || dec_cnt !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL por: out_valid=%b dec_cnt=%0d in_ready=%b exp 0/0/1", out_valid, dec_cnt, in_ready);
    end
    rst_n = 1'b1;
    tick;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(k);
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || dec_cnt !== 32'd5) begin
      errors++;
      $display("FAIL pre_reset: out_valid=%b dec_cnt=%0d exp 1/5", out_valid, dec_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_pc, rs1, rs2, rd, rs1_en, rs2_en, wr_reg_en, imm, alu_ctrl, alu_w_op,
         pc_src, rd_mem_en, wr_mem_en, mem_len, mem_unsigned, mem2reg_en, ebreak, illegal,
         dec_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset64: out_valid=%b pc=%h imm=%h alu=%h dec_cnt=%0d exp all 0",
               out_valid, out_pc, imm, alu_ctrl, dec_cnt);
    end
    checks++;
    if ({out_valid_32, out_pc_32, rd_32, imm_32, alu_ctrl_32, illegal_32, dec_cnt_32} !== '0) begin
      errors++;
      $display("FAIL async_reset32: out_valid=%b imm=%h dec_cnt=%0d exp all 0",
               out_valid_32, imm_32, dec_cnt_32);
    end
    sb.delete();
    n_acc = 0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_addi;
    logic [31:0] base;
    base = dec_cnt;
    out_ready = 1'b1;
    drive(0);
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl[0] !== 1'b1 || imm !== 64'hffffffffffffffff ||
        rd !== 5'd1 || wr_reg_en !== 1'b1) begin
      errors++;
      $display("FAIL addi: valid=%b alu=%h imm=%h rd=%0d wr=%b exp 1/1/ffffffffffffffff/1/1",
               out_valid, alu_ctrl, imm, rd, wr_reg_en);
    end
    tick;
    checks++;
    if (dec_cnt !== base + 32'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL addi_cnt: dec_cnt=%0d valid=%b exp %0d/0", dec_cnt, out_valid, base + 1);
    end
  endtask

  task automatic test_back_to_back;
    int          idx, cyc;
    logic        acc;
    logic [31:0] base;
    logic [63:0] snap_pc, snap_imm;
    logic [24:0] snap_alu;
    int          list [4] = '{1, 2, 4, 5};
    base = dec_cnt; idx = 0; cyc = 0;
    snap_pc = '0; snap_imm = '0; snap_alu = '0;
    drive(list[0]);
    while (idx < 4 && cyc < 40) begin
      out_ready = !(cyc == 2 || cyc == 3);
      #1;
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_ready: in_ready=%b out_valid=%b exp 0/1", in_ready, out_valid);
        end
        if (cyc == 2) begin
          snap_pc = out_pc; snap_imm = imm; snap_alu = alu_ctrl;
        end else begin
          checks++;
          if (out_pc !== snap_pc || imm !== snap_imm || alu_ctrl !== snap_alu) begin
            errors++;
            $display("FAIL stall_hold: pc=%h imm=%h alu=%h exp %h/%h/%h",
                     out_pc, imm, alu_ctrl, snap_pc, snap_imm, snap_alu);
          end
        end
      end
      acc = in_ready;
      tick;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 4) drive(list[idx]);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (idx < 4) begin
      errors++;
      $display("FAIL b2b_timeout: sent %0d of 4", idx);
    end
    out_ready = 1'b1;
    repeat (3) tick;
    checks++;
    if (dec_cnt !== base + 32'd4) begin
      errors++;
      $display("FAIL b2b_cnt: dec_cnt=%0d exp %0d", dec_cnt, base + 4);
    end
  endtask

  task automatic test_xlen32;
    out_ready = 1'b1;
    drive(1);
    tick;
    checks++;
    if (illegal_32 !== 1'b1 || wr_reg_en_32 !== 1'b0 || alu_ctrl_32 !== 25'h0) begin
      errors++;
      $display("FAIL srai_rv32: ill=%b wr=%b alu=%h exp 1/0/0", illegal_32, wr_reg_en_32, alu_ctrl_32);
    end
    drive(2);
    tick;
    checks++;
    if (illegal_32 !== 1'b1 || rd_mem_en_32 !== 1'b0) begin
      errors++;
      $display("FAIL ld_rv32: ill=%b rd_mem_en=%b exp 1/0", illegal_32, rd_mem_en_32);
    end
    drive(0);
    tick;
    in_valid = 1'b0;
    checks++;
    if (illegal_32 !== 1'b0 || imm_32 !== 32'hffffffff || wr_reg_en_32 !== 1'b1 || out_valid_32 !== 1'b1) begin
      errors++;
      $display("FAIL addi_rv32: ill=%b imm=%h wr=%b valid=%b exp 0/ffffffff/1/1",
               illegal_32, imm_32, wr_reg_en_32, out_valid_32);
    end
    tick;
  endtask

  task automatic test_flush;
    logic [31:0] base;
    out_ready = 1'b0;
    drive(5);
    tick;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: out_valid=%b exp 1", out_valid);
    end
    base = dec_cnt;
    drive(6);
    flush = 1'b1; out_ready = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || dec_cnt !== base) begin
      errors++;
      $display("FAIL flush: out_valid=%b dec_cnt=%0d exp 0/%0d", out_valid, dec_cnt, base);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0 || dec_cnt !== base) begin
      errors++;
      $display("FAIL flush_after: out_valid=%b dec_cnt=%0d exp 0/%0d", out_valid, dec_cnt, base);
    end
  endtask

  task automatic test_mext;
    out_ready = 1'b1;
    drive(3);
    tick;
    in_valid = 1'b0;
    checks++;
`ifdef IDU_PIPE_RVM_EN
    if (alu_ctrl !== 25'h20000 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL mul: alu=%h ill=%b exp 20000/0", alu_ctrl, illegal);
    end
`else
    if (alu_ctrl !== 25'h0 || illegal !== 1'b1) begin
      errors++;
      $display("FAIL mul: alu=%h ill=%b exp 0/1", alu_ctrl, illegal);
    end
`endif
    tick;
  endtask

  task automatic test_stream;
    int   idx, cyc;
    logic acc;
    idx = 0; cyc = 0;
    drive(0);
    while (idx < 12 && cyc < 300) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_ready;
      tick;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 12) drive(idx);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (idx < 12) begin
      errors++;
      $display("FAIL stream_timeout: sent %0d of 12", idx);
    end
    out_ready = 1'b1;
    repeat (3) tick;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d bundles never emitted, exp 0", sb.size());
    end
    checks++;
    if (dec_cnt !== 32'(n_acc) || dec_cnt_32 !== 3'(n_acc)) begin
      errors++;
      $display("FAIL dec_cnt_total: cnt64=%0d cnt32=%0d exp %0d/%0d",
               dec_cnt, dec_cnt_32, n_acc, n_acc % 8);
    end
  endtask

  initial begin
    init_table();
    test_reset();
    test_addi();
    test_back_to_back();
    test_xlen32();
    test_flush();
    test_mext();
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/idu_pipe.md
Name: idu_pipe

Overview:
- Registered, handshaked instruction-decode stage. Sits between instruction fetch and the ctrl/regfile/alu/data_mem consumers.
- Decodes RV32I/RV64I for a selectable XLEN and flags illegal encodings.
- Holds one decoded instruction in an output pipeline register with valid/ready flow control, flush, and a decoded-instruction counter.
- Optionally decodes the M extension.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64; sizes imm and pc.
- CNT_W, 32, width of the decoded-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents instr/pc
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  consumer accepts bundle
- out_pc  out  XLEN  registered pc
- rs1, rs2, rd  out  5 each  register indices
- rs1_en, rs2_en, wr_reg_en  out  1 each  register usage/writeback
- imm  out  XLEN  sign-extended immediate
- alu_ctrl  out  25  one-hot ALU op
- alu_w_op  out  1  32-bit op, sign-extend result (XLEN=64 only)
- pc_src  out  4  [0] branch, [1] jal, [2] jalr, [3] auipc
- rd_mem_en, wr_mem_en  out  1 each  load/store
- mem_len  out  4  bytes: 1/2/4/8
- mem_unsigned  out  1  zero-extend load
- mem2reg_en  out  1  writeback source is memory
- ebreak  out  1  instr == 32'h00100073
- illegal  out  1  unsupported/malformed encoding
- dec_cnt  out  CNT_W  count of bundles accepted downstream

Behaviour:
- Reset (rst_n low, async): out_valid=0, every registered output=0, dec_cnt=0. Reset mid-transfer drops the held bundle.
- in_ready = ~out_valid | out_ready, combinational; it does not depend on in_valid.
- Load: when in_valid & in_ready & ~flush, the decoded bundle is registered. Latency is 1 cycle and full throughput is 1 per cycle.
- Hold: when out_valid & ~out_ready, all outputs stay stable.
- Empty: out_valid drops when the bundle is accepted with no new input.
- Flush: has priority over load. The next cycle has out_valid=0, and the input offered in the flush cycle is dropped. The flush cycle never counts toward dec_cnt.
- dec_cnt increments on out_valid & out_ready and wraps modulo 2^CNT_W.
- alu_ctrl bit map:
  - 0 add (addi/add/addw/addiw/loads/stores/jal/jalr/auipc)
  - 1 sub
  - 2 slt
  - 3 sltu
  - 4 and
  - 5 xor
  - 6 or
  - 7 sll
  - 8 srl
  - 9 sra
  - 10 lui
  - 11–16 beq/bne/blt/bge/bltu/bgeu
  - 17–24 mul/mulh/mulhsu/mulhu/div/divu/rem/remu
- W forms (opcodes 0111011 and 0011011) set alu_w_op plus the base bit.
- Immediates are sign-extended to XLEN per I/S/B/U/J format.
- Shift-immediates (slli/srli/srai, W forms): imm = zero-extended shamt.
  - Shamt width: XLEN=64 uses instr[25:20] (W forms instr[24:20]); XLEN=32 uses instr[24:20].
  - instr[25]=1 with XLEN=32 is illegal; instr[25]=1 on W shifts is illegal.
- Register usage:
  - rs1_en for R/I/S/B/jalr.
  - rs2_en for R/S/B.
  - wr_reg_en = ~(branch|store) & ~illegal & ~ebreak.
- Illegal when any of the following holds:
  - instr[1:0]≠11 or unknown opcode
  - R-type funct7 not 0000000/0100000, or 0100000 outside sub/sra/subw/sraw
  - branch funct3 010/011; jalr funct3≠0
  - load funct3 111; store funct3 1xx
  - XLEN=32 and (ld, lwu, sd, any W opcode)
  - SYSTEM opcode other than ebreak
  - funct7=0000001 without the M feature
- Illegal side effects: all enables (rs*, wr_reg, rd_mem, wr_mem, pc_src, alu_ctrl) are forced to 0. illegal=1 and the bundle still flows with out_valid=1.
- Loads: rd_mem_en=1, mem2reg_en=1, mem_len per funct3, mem_unsigned for lbu/lhu/lwu. ld is a normal load with len 8.
- Stores: wr_mem_en=1, mem_len per funct3.

Optional Feature:
- Macro: IDU_PIPE_RVM_EN.
- Defined: funct7=0000001 on opcode 0110011 decodes to alu_ctrl[24:17].
  - With XLEN=64, on opcode 0111011 it decodes mulw/divw/divuw/remw/remuw as the base bit plus alu_w_op; W funct3 001/010/011 are illegal.
- Undefined: alu_ctrl[24:17] is tied to 0, and every funct7=0000001 R/RW encoding is illegal.

Test Plan:
- Reset with out_valid=1 and dec_cnt=5 → immediately out_valid=0, all outputs 0, dec_cnt=0.
- XLEN=64, addi x1,x0,-1 (32'hfff00093) with out_ready=1 → next cycle out_valid=1, alu_ctrl[0]=1, imm=64'hffffffffffffffff, rd=1, wr_reg_en=1, dec_cnt=1 after handshake.
- Back-to-back stream of 4 instructions, out_ready low for 2 cycles mid-stream → in_ready=0 while stalled, held bundle stable, no loss/duplication, dec_cnt=4.
- srai x2,x2,33 (32'h42115113) → imm=33, alu_ctrl[9]=1. With XLEN=32 → illegal=1, wr_reg_en=0.
- flush asserted while out_valid=1 and in_valid=1 → next cycle out_valid=0, dec_cnt unchanged. ld (32'h0000b183) with XLEN=32 → illegal=1, rd_mem_en=0.
- mul x3,x1,x2 (32'h022081b3): with IDU_PIPE_RVM_EN → alu_ctrl[17]=1, illegal=0. Without it → illegal=1, alu_ctrl=0.
